// File: rtl/inst_fetch_resp.sv
// ---------------------------------------------------------------------------
// inst_fetch_resp
// Instruction-fetch responder. Takes the PC from the PC generator, reads the
// addressed word from an internal instruction memory after WAIT_CYCLES wait
// states, and hands the instruction plus its address to decode. While a fetch
// is in flight it asks ctrl to stall the PC; a jump aborts the fetch.
// The memory is preloaded through a loader write port.
//
// Parameters
//   WAIT_CYCLES  wait states per fetch (0..15); 0 gives single-cycle fetch
//   DEPTH        instruction memory size in 32-bit words (power of two)
// Ports
//   clk, rst       clock; synchronous active-high reset
//   pc_i           fetch address
//   jump_flag_i    jump/flush in progress (aborts any fetch)
//   hold_flag_i    stall level from ctrl; this block stalls at 2 or more
//   load_we_i      loader write strobe
//   load_addr_i    loader byte address (word aligned)
//   load_data_i    loader write data
//   inst_o         fetched instruction (NOP after reset/jump/fault)
//   inst_addr_o    address of inst_o
//   inst_valid_o   inst_o/inst_addr_o hold a real fetch result
//   err_o          fetch fault (misaligned or out of range)
//   hold_req_o     combinational stall request to ctrl
// ---------------------------------------------------------------------------
module inst_fetch_resp #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        jump_flag_i,
    input  logic [2:0]  hold_flag_i,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        err_o,
    output logic        hold_req_o
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic        stalled;
    logic        acc;
    logic        deliver;
    logic [31:0] fetch_addr;
    logic        fetch_fault;
    logic [31:0] rd_word;

    function automatic logic in_range(input logic [31:0] a);
        return {2'b00, a[31:2]} < 32'(DEPTH);
    endfunction

    // Loader port: out-of-range writes are dropped rather than aliased.
    // Not gated by rst so a program can be loaded while the core is held.
    always_ff @(posedge clk) begin
        if (load_we_i && in_range(load_addr_i)) begin
            mem[load_addr_i[AW+1:2]] <= load_data_i;
        end
    end

    assign stalled = (hold_flag_i >= 3'd2);
    assign acc     = (state_q == IDLE) && !jump_flag_i && !stalled;

    // In IDLE a zero-wait fetch uses the live PC; in BUSY the latched address.
    assign fetch_addr  = (state_q == BUSY) ? addr_q : pc_i;
    assign fetch_fault = (fetch_addr[1:0] != 2'b00) || !in_range(fetch_addr);
    // Read happens before the same-edge loader write lands, so a colliding
    // write is seen as old data.
    assign rd_word     = mem[fetch_addr[AW+1:2]];

    // Drops in the completion cycle (cnt=1) so the PC advances on the same
    // edge the instruction is delivered.
    assign hold_req_o = !rst && !jump_flag_i &&
                        ((acc && (WAIT_CYCLES != 0)) ||
                         ((state_q == BUSY) && (cnt_q > 4'd1)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        valid_d     = valid_q;
        err_d       = err_q;
        deliver     = 1'b0;

        if (jump_flag_i) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            inst_d  = NOP;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (state_q == IDLE) begin
            if (!stalled) begin
                if (WAIT_CYCLES == 0) begin
                    deliver = 1'b1;
                end else begin
                    addr_d  = pc_i;
                    cnt_d   = WAIT_INIT;
                    state_d = BUSY;
                end
            end
        end else begin
            // The countdown keeps running during a stall but parks at 1,
            // so completion happens on the first unstalled cycle.
            if (cnt_q > 4'd1) begin
                cnt_d = cnt_q - 4'd1;
            end else if (!stalled) begin
                deliver = 1'b1;
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        end

        if (deliver) begin
            inst_addr_d = fetch_addr;
            valid_d     = 1'b1;
            err_d       = fetch_fault;
            inst_d      = fetch_fault ? NOP : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            inst_q      <= NOP;
            inst_addr_q <= 32'd0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = valid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_resp
// Drives a zero-wait instance (index 0) and a two-wait-state instance
// (index 1) from the same inputs. A transaction-level reference model of each
// instance is checked every cycle; a vector table and hand-written sequences
// add fixed expectations for the listed corner cases, followed by random
// traffic.
// ---------------------------------------------------------------------------
module tb_inst_fetch_resp;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, jump, we;
    logic [2:0]  hold;
    logic [31:0] pc, la, ld;

    logic [31:0] inst_w  [2];
    logic [31:0] iaddr_w [2];
    logic        valid_w [2];
    logic        err_w   [2];
    logic        hreq_w  [2];

    always #5 clk = ~clk;

    inst_fetch_resp #(.WAIT_CYCLES(0), .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .pc_i(pc), .jump_flag_i(jump), .hold_flag_i(hold),
        .load_we_i(we), .load_addr_i(la), .load_data_i(ld),
        .inst_o(inst_w[0]), .inst_addr_o(iaddr_w[0]), .inst_valid_o(valid_w[0]),
        .err_o(err_w[0]), .hold_req_o(hreq_w[0])
    );

    inst_fetch_resp #(.WAIT_CYCLES(2), .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .pc_i(pc), .jump_flag_i(jump), .hold_flag_i(hold),
        .load_we_i(we), .load_addr_i(la), .load_data_i(ld),
        .inst_o(inst_w[1]), .inst_addr_o(iaddr_w[1]), .inst_valid_o(valid_w[1]),
        .err_o(err_w[1]), .hold_req_o(hreq_w[1])
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    logic [31:0] mem_m [DEPTH];
    bit          m_busy  [2];
    int          m_el    [2];   // edges elapsed since the accept edge
    logic [31:0] m_addr  [2];
    logic [31:0] m_inst  [2];
    logic [31:0] m_iaddr [2];
    bit          m_valid [2];
    bit          m_err   [2];
    logic        hr      [2];   // hold_req sampled before the last edge

    function automatic int wv(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic bit mfault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic deliver(input int k, input logic [31:0] a);
        m_iaddr[k] = a;
        m_valid[k] = 1'b1;
        m_err[k]   = mfault(a);
        m_inst[k]  = mfault(a) ? NOP : mem_m[a >> 2];
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_el[k] = 0; m_addr[k] = 0;
            m_inst[k] = NOP; m_iaddr[k] = 0; m_valid[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_edge(input bit stl);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 0; m_el[k] = 0;
                m_inst[k] = NOP; m_iaddr[k] = 0; m_valid[k] = 0; m_err[k] = 0;
            end else if (jump) begin
                m_busy[k] = 0; m_el[k] = 0;
                m_inst[k] = NOP; m_valid[k] = 0; m_err[k] = 0;
            end else if (!m_busy[k]) begin
                if (!stl) begin
                    if (wv(k) == 0) deliver(k, pc);
                    else begin
                        m_busy[k] = 1; m_addr[k] = pc; m_el[k] = 0;
                    end
                end
            end else begin
                m_el[k]++;
                if (m_el[k] >= wv(k) && !stl) begin
                    deliver(k, m_addr[k]);
                    m_busy[k] = 0;
                end
            end
        end
        // Write lands after the reads above: same-edge read sees old data.
        if (we && ((la >> 2) < DEPTH)) mem_m[la >> 2] = ld;
    endtask

    // One clock cycle: check stall request before the edge, outputs after.
    task automatic tick();
        bit stl;
        bit exp_h;
        #1;
        stl = (hold >= 3'd2);
        for (int k = 0; k < 2; k++) begin
            exp_h = !rst && !jump &&
                    ((!m_busy[k] && !stl && wv(k) > 0) ||
                     (m_busy[k] && (m_el[k] + 1 < wv(k))));
            hr[k] = hreq_w[k];
            chk($sformatf("model_hold_req[%0d]", k), hr[k], exp_h);
        end
        @(posedge clk);
        model_edge(stl);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_inst[%0d]", k),  inst_w[k],  m_inst[k]);
            chk($sformatf("model_addr[%0d]", k),  iaddr_w[k], m_iaddr[k]);
            chk($sformatf("model_valid[%0d]", k), valid_w[k], m_valid[k]);
            chk($sformatf("model_err[%0d]", k),   err_w[k],   m_err[k]);
        end
    endtask

    task automatic expect1(input string nm, input logic [31:0] i, input logic [31:0] a,
                           input bit v, input bit e);
        chk({nm, "_inst"},  inst_w[1],  i);
        chk({nm, "_addr"},  iaddr_w[1], a);
        chk({nm, "_valid"}, valid_w[1], v);
        chk({nm, "_err"},   err_w[1],   e);
    endtask

    // ---------------- vector table for the zero-wait instance ----------------
    typedef struct {
        logic [31:0] pc;
        logic [2:0]  hold;
        bit          jump;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
        bit          e_valid;
        bit          e_err;
    } vec_t;

    vec_t tv [11];

    initial begin
        int r;
        tv[0]  = '{32'h0,    3'd0, 1'b0, 32'h11,        32'h0,    1'b1, 1'b0};
        tv[1]  = '{32'h4,    3'd0, 1'b0, 32'h22,        32'h4,    1'b1, 1'b0};
        tv[2]  = '{32'h8,    3'd0, 1'b0, 32'h33,        32'h8,    1'b1, 1'b0};
        tv[3]  = '{32'hC,    3'd0, 1'b0, 32'h44,        32'hC,    1'b1, 1'b0};
        tv[4]  = '{32'h6,    3'd0, 1'b0, NOP,           32'h6,    1'b1, 1'b1};
        tv[5]  = '{32'h4000, 3'd0, 1'b0, NOP,           32'h4000, 1'b1, 1'b1};
        tv[6]  = '{32'h10,   3'd2, 1'b0, NOP,           32'h4000, 1'b1, 1'b1};
        tv[7]  = '{32'h10,   3'd3, 1'b0, NOP,           32'h4000, 1'b1, 1'b1};
        tv[8]  = '{32'h10,   3'd1, 1'b0, 32'hDEADBEEF,  32'h10,   1'b1, 1'b0};
        tv[9]  = '{32'h14,   3'd0, 1'b1, NOP,           32'h10,   1'b0, 1'b0};
        tv[10] = '{32'h0,    3'd0, 1'b0, 32'h11,        32'h0,    1'b1, 1'b0};

        rst = 1; jump = 0; hold = 0; pc = 0; we = 0; la = 0; ld = 0;
        model_reset();

        // Preload words 0..63 while reset is asserted.
        for (int i = 0; i < 64; i++) begin
            we = 1; la = i * 4;
            if (i < 4)       ld = 32'h11 * (i + 1);
            else if (i == 4) ld = 32'hDEADBEEF;
            else if (i == 8) ld = 32'h0BADF00D;
            else             ld = $urandom;
            tick();
        end
        chk("reset_inst",  inst_w[1],  NOP);
        chk("reset_valid", valid_w[1], 1'b0);
        we = 0; rst = 0;

        for (int i = 0; i < 11; i++) begin
            pc = tv[i].pc; hold = tv[i].hold; jump = tv[i].jump;
            tick();
            chk($sformatf("tv%0d_inst", i),  inst_w[0],  tv[i].e_inst);
            chk($sformatf("tv%0d_addr", i),  iaddr_w[0], tv[i].e_addr);
            chk($sformatf("tv%0d_valid", i), valid_w[0], tv[i].e_valid);
            chk($sformatf("tv%0d_err", i),   err_w[0],   tv[i].e_err);
            chk($sformatf("tv%0d_hreq", i),  hr[0],      1'b0);
        end
        hold = 0; jump = 0;

        // Clean start for the two-wait-state sequences.
        rst = 1; tick(); rst = 0;

        // Basic fetch with two wait states.
        pc = 32'h10;
        tick(); chk("w2_hreq_c1", hr[1], 1'b1); chk("w2_valid_c1", valid_w[1], 1'b0);
        tick(); chk("w2_hreq_c2", hr[1], 1'b1); chk("w2_valid_c2", valid_w[1], 1'b0);
        tick(); chk("w2_hreq_c3", hr[1], 1'b0);
        expect1("w2_done", 32'hDEADBEEF, 32'h10, 1'b1, 1'b0);

        // Jump one cycle into BUSY aborts the fetch of word 0.
        pc = 32'h0;
        tick();
        jump = 1; tick();
        chk("jmp_valid", valid_w[1], 1'b0); chk("jmp_inst", inst_w[1], NOP);
        jump = 0; pc = 32'h4;
        tick(); chk("jmp_accept_hreq", hr[1], 1'b1); chk("jmp_bubble1", valid_w[1], 1'b0);
        tick(); chk("jmp_bubble2", valid_w[1], 1'b0);
        tick(); expect1("jmp_new", 32'h22, 32'h4, 1'b1, 1'b0);

        // Stall for five cycles during BUSY: outputs hold, completes on release.
        pc = 32'h8;
        tick();
        hold = 3'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect1($sformatf("stall%0d", i), 32'h22, 32'h4, 1'b1, 1'b0);
        end
        hold = 3'd0;
        tick(); expect1("stall_rel", 32'h33, 32'h8, 1'b1, 1'b0);

        // Loader write colliding with fetch completion returns old data.
        pc = 32'h20;
        tick(); tick();
        we = 1; la = 32'h20; ld = 32'hA5A5A5A5;
        tick(); chk("coll_old", inst_w[1], 32'h0BADF00D);
        we = 0;
        tick(); tick(); tick(); chk("coll_new", inst_w[1], 32'hA5A5A5A5);

        // Faults.
        pc = 32'h6;
        tick(); tick(); tick(); expect1("misalign", NOP, 32'h6, 1'b1, 1'b1);
        pc = DEPTH * 4;
        tick(); tick(); tick(); expect1("oob", NOP, DEPTH * 4, 1'b1, 1'b1);

        // Reset mid-BUSY: no completion.
        pc = 32'h0;
        tick();
        rst = 1; tick(); expect1("rst_busy", NOP, 32'h0, 1'b0, 1'b0);
        rst = 0;
        tick(); chk("rst_busy_after", valid_w[1], 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       pc = $urandom_range(0, 63) << 2;
            else if (r == 8) pc = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
            else             pc = 32'h4000 + ($urandom_range(0, 255) << 2);
            hold = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(0, 3));
            jump = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 63) == 0);
            we   = ($urandom_range(0, 4) == 0);
            la   = ($urandom_range(0, 4) == 0) ? 32'h4000 + ($urandom_range(0, 63) << 2)
                                               : ($urandom_range(0, 63) << 2);
            ld   = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
